// File: rtl/jb_target_predictor.sv
// Direct-mapped branch target buffer with same-cycle lookup and EX-driven training/redirect.
// Optional build macro JB_PREDICTOR_STATS_EN adds 32-bit lookup/hit/update/mispredict counters.
module jb_target_predictor #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc
`ifdef JB_PREDICTOR_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << IDX_W;

    logic              valid_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [30:0]       tgt_q   [ENTRIES];
    logic [1:0]        ctr_q   [ENTRIES];

    logic [IDX_W-1:0]  f_idx;
    logic [TAG_W-1:0]  f_tag;
    logic              f_hit;
    logic [IDX_W-1:0]  u_idx;
    logic [TAG_W-1:0]  u_tag;
    logic              u_hit;
    logic              unused_bits;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // Fetch-side lookup: purely combinational from the table registers.
    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[31:IDX_W+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign pred_taken  = f_hit && ctr_q[f_idx][1];
    assign pred_target = pred_taken ? {tgt_q[f_idx], 1'b0} : 32'd0;

    // Fetch PCs are word aligned, so the low bits never select anything.
    assign unused_bits = ^fetch_pc[1:0];

    // Mispredict detection depends only on the EX-side inputs.
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        if (upd_valid) begin
            if (upd_taken && (!upd_pred_taken || (upd_pred_target != upd_target))) begin
                redirect    = 1'b1;
                redirect_pc = upd_target;
            end else if (!upd_taken && upd_pred_taken) begin
                redirect    = 1'b1;
                redirect_pc = upd_pc + 32'd4;
            end
        end
    end

    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Training stage: new contents become visible to lookups on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    ctr_q[u_idx] <= ctr_inc(ctr_q[u_idx]);
                    tgt_q[u_idx] <= upd_target[31:1];
                end else begin
                    ctr_q[u_idx] <= ctr_dec(ctr_q[u_idx]);
                end
            end else if (upd_taken) begin
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= u_tag;
                tgt_q[u_idx]   <= upd_target[31:1];
                ctr_q[u_idx]   <= 2'b10;
            end
        end
    end

`ifdef JB_PREDICTOR_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups     <= 32'd0;
            stat_hits        <= 32'd0;
            stat_updates     <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            stat_lookups <= stat_lookups + 32'd1;
            if (f_hit)
                stat_hits <= stat_hits + 32'd1;
            if (upd_valid)
                stat_updates <= stat_updates + 32'd1;
            if (redirect)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: doc/jb_target_predictor.md
Name: jb_target_predictor

Overview:
- Fetch-side branch target buffer (BTB) that consumes the resolved jump/branch target produced in EX.
- Lookup side: predicts taken/target for the fetch PC in the same cycle.
- Update side: takes resolved outcome and target from EX, trains the tables and issues a redirect/flush on misprediction.
- Sits between IF (PC mux) and EX (jump/branch resolution).

Parameters:
- IDX_W, 4, index width; entries = 2**IDX_W, direct-mapped.
- TAG_W, 26, tag width = 32 - IDX_W - 2; must equal that value.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- fetch_pc  input  32  PC being fetched this cycle
- pred_taken  output  1  predict taken for fetch_pc (combinational)
- pred_target  output  32  predicted target; 0 when pred_taken=0
- upd_valid  input  1  EX holds a resolved jump/branch this cycle
- upd_pc  input  32  PC of the resolved instruction
- upd_taken  input  1  actual outcome (1 for JAL/JALR)
- upd_target  input  32  actual target from EX (bit0 already cleared for JALR)
- upd_pred_taken  input  1  prediction made at fetch, piped to EX
- upd_pred_target  input  32  predicted target, piped to EX
- redirect  output  1  mispredict; flush IF/ID, load redirect_pc (combinational)
- redirect_pc  output  32  correct next PC; 0 when redirect=0

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- Per entry: valid (1b), tag (TAG_W), target[31:1] (31b; bit0 is reconstructed as 0), ctr (2b saturating).
- Lookup (combinational from table registers):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = {target,1'b0} when pred_taken, else 0.
- Mispredict detection (combinational, only when upd_valid=1):
  - upd_taken=1 and (upd_pred_taken=0 or upd_pred_target!=upd_target): redirect=1, redirect_pc=upd_target.
  - upd_taken=0 and upd_pred_taken=1: redirect=1, redirect_pc=upd_pc+4 (32-bit wrap).
  - Otherwise, or when upd_valid=0: redirect=0, redirect_pc=0.
- Table update (on clock edge when upd_valid=1, indexed by upd_pc):
  - Hit, taken: ctr increments, saturating at 3; target <= upd_target[31:1].
  - Hit, not taken: ctr decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate and overwrite any existing entry; valid=1, tag written, target written, ctr=2'b10.
  - Miss, not taken: no change.
- Same-cycle lookup and update on the same index: lookup returns pre-update contents; new contents are visible next cycle.
- Reset:
  - All valid=0, ctr=2'b01, tag/target=0.
  - Therefore pred_taken=0 and pred_target=0 in the cycle after reset is sampled.
  - redirect/redirect_pc depend only on inputs; they are 0 whenever upd_valid=0.
  - rst asserted mid-operation with upd_valid=1: reset wins and no table write occurs.
- Latency:
  - Prediction: 0 cycles.
  - Training: visible to lookups 1 cycle after the upd_valid edge.

Optional Feature:
- Macro: JB_PREDICTOR_STATS_EN.
- When defined, adds output ports:
  - stat_lookups (32): +1 per cycle.
  - stat_hits (32): +1 per cycle with hit=1.
  - stat_updates (32): +1 per upd_valid.
  - stat_mispredicts (32): +1 per redirect.
- Counters wrap at 2^32 and are cleared to 0 by rst.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then fetch_pc=0x00000100 -> pred_taken=0, pred_target=0 for all 16 indices.
- upd_valid, upd_pc=0x100, taken, target=0x200, pred_taken=0 -> redirect=1, redirect_pc=0x200 same cycle; next cycle fetch_pc=0x100 -> pred_taken=1, pred_target=0x200 (ctr=2).
- Entry from previous test: two not-taken updates with upd_pred_taken=1 -> redirect_pc=0x104 each time; ctr 2->1->0; fetch 0x100 -> pred_taken=0. Then one taken update -> ctr=1, still predicts not taken.
- Alias: train 0x100->0x200, then taken update at 0x140 (same index, IDX_W=4) -> fetch 0x100 misses, fetch 0x140 hits target.
- JALR-style update target=0x0000_0302 with matching prediction -> redirect=0; stored/predicted target reads 0x302 with bit0=0. Same-cycle fetch of the updated index returns old data.
- rst asserted with upd_valid=1 -> no entry written; with JB_PREDICTOR_STATS_EN, counters read 0 and then increment exactly per rule over 10 scripted cycles.
